spi_ahb_loader: RTL and testbench
=================================

# spi_ahb_loader

Boot-time loader that receives an SPI serial stream from an external host and turns it into single-word AHB-lite write transfers. Its AHB master port drives the router's SPI-side inputs, which place data in instruction RAM, data RAM or the register bank (addr[15:14] = 00 / 01 / 1x). When the host sends the run command, the loader pulses spi_change so the router hands the memories over to the RISC-V core.

## Interface
- SYNC_STAGES, 2: flip-flop depth of the sclk/cs_n/mosi synchronizers (≥2).
- HPROT_VAL, 4'b0011: constant driven on hprot.
- clk  in  1  system clock; must be ≥4× sclk.
- reset  in  1  synchronous, active-high.
- sclk, cs_n, mosi  in  1 each  SPI mode 0, asynchronous to clk, MSB first.
- miso  out  1  status byte, MSB first.
- haddr  out  32  AHB address, bits[1:0] always 0.
- htrans  out  2  00 IDLE / 10 NONSEQ only.
- hwrite  out  1  1 during NONSEQ, else 0.
- hsize / hburst / hprot / hmastlock  out  3/3/4/1  constant 3'b010 / 3'b000 / HPROT_VAL / 0.
- hwdata  out  32  write data, valid in data phase.
- hready, hresp  in  1 each  AHB slave response.
- spi_change  out  1  one-cycle run pulse to router.
- busy  out  1  AHB transfer in address or data phase.
- error  out  1  sticky: hresp error or overrun.

## Operation
- Byte receiver: synchronize inputs; mosi sampled on detected sclk rise; byte_valid after 8 bits. Bit counter cleared while cs_n high.
- miso: status {5'b0, error, spi_change_sent, busy} loaded at each byte start, shifted out on detected sclk fall.
- Parser FSM: P_IDLE → (cs_n low) P_CMD.
  - P_CMD, byte 0x02 → P_ADDR; 0xA5 → P_RUN; other → P_DISCARD.
  - P_ADDR: 4 bytes big-endian into addr register, low 2 bits forced 0 → P_DATA.
  - P_DATA: every 4 bytes (big-endian) form one word → write request with current addr; addr += 4 (32-bit wrap to 0).
  - P_RUN: wait until AHB FSM idle, pulse spi_change one cycle, set spi_change_sent → P_DISCARD.
  - P_DISCARD: ignore bytes.
  - cs_n rising in any state → P_IDLE; partial word/address dropped; pending AHB transfer still completes.
- AHB FSM: A_IDLE → A_ADDR on request (one-word holding buffer). A_ADDR drives NONSEQ, hwrite=1, haddr; advances to A_DATA on the first cycle with hready=1. A_DATA drives hwdata, htrans=IDLE; completes on hready=1 → A_IDLE (or A_ADDR if buffer full).
- hresp=1 at completion sets error; no retry.
- Word completes while holding buffer occupied → word dropped, error set.
- error and spi_change_sent cleared only by reset.

## Timing
- Reset: htrans=00, hwrite=0, haddr=0, hwdata=0, miso=0, spi_change=0, busy=0, error=0, parser P_IDLE, AHB A_IDLE.
- Input latency: SYNC_STAGES+1 clk from sclk edge to sample.
- Last data bit sampled → NONSEQ on haddr: 2 clk.
- Address phase ≥1 clk; data phase ≥1 clk, extended while hready=0; hwdata/haddr stable while extended.
- spi_change asserted ≥1 clk after final 0xA5 bit and after busy=0.

## Structure
- Package loader_pkg: CMD_WRITE=8'h02, CMD_RUN=8'hA5, HTRANS_IDLE/NONSEQ, HSIZE_WORD, parser and AHB state enums.
- Sub-module spi_byte_rx: synchronizers, edge detect, rx/tx shift registers, byte_valid, miso. Top holds parser, holding buffer, AHB FSM.

## Test plan
- Reset mid-transfer → next clk all outputs at reset values, htrans=00.
- Frame 02 00 00 00 10 DE AD BE EF, cs_n high → one NONSEQ, haddr=0x10, hwdata=0xDEADBEEF, hwrite=1.
- Two words after address 0xFFFFFFFC → haddr 0xFFFFFFFC then 0x00000000.
- hready low 5 clk in data phase → hwdata/haddr stable, busy=1 throughout, next NONSEQ only after hready=1.
- cs_n raised after 2 data bytes → no transfer; following frame writes correctly.
- Byte 0xA5 → spi_change high exactly 1 clk; status byte then reads 0x02; hresp=1 on a write → error=1, status bit 2 set.

Source files
------------

// File: rtl/spi_ahb_loader_pkg.sv
// Shared constants and state encodings for the SPI-to-AHB boot loader.
package loader_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_RUN       = 8'hA5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    P_IDLE,
    P_CMD,
    P_ADDR,
    P_DATA,
    P_RUN,
    P_DISCARD
  } parser_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ADDR,
    A_DATA
  } ahb_state_t;

endpackage

// File: rtl/spi_ahb_loader_if.sv
// AHB-lite single-master bus between the loader and the router's SPI-side inputs.
interface spi_ahb_loader_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hready, hresp
  );
endinterface

// File: rtl/spi_ahb_loader_spi_byte_rx.sv
// SPI mode-0 byte receiver: synchronizes the host pins, assembles MSB-first
// bytes on sclk rise and shifts the status byte out on miso on sclk fall.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic [7:0] status,
  output logic       cs_idle,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       miso
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_prev;
  logic       sclk_s, mosi_s, rise, fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_idle = cs_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev;
  assign fall    = ~sclk_s & sclk_prev;
  assign miso    = tx_shift[7];

  // NOTE: every register updates with <= so all flops see pre-edge values;
  // reset is sampled on clk, matching the rest of the codebase.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync  <= '0;
      cs_sync    <= '1;
      mosi_sync  <= '0;
      sclk_prev  <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      tx_shift   <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev  <= sclk_s;
      byte_valid <= 1'b0;
      if (cs_idle) begin
        bit_cnt  <= '0;
        tx_shift <= status;
      end else begin
        if (rise) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            rx_byte    <= {rx_shift, mosi_s};
          end
        end
        // Between bytes the status keeps refreshing so the next byte reports it fresh.
        if (fall && bit_cnt != 3'd0) tx_shift <= {tx_shift[6:0], 1'b0};
        else if (bit_cnt == 3'd0)    tx_shift <= status;
      end
    end
  end

endmodule

// File: rtl/spi_ahb_loader.sv
// Boot loader top: parses SPI command frames into single-word AHB-lite writes
// through a one-word holding buffer, and issues the run pulse to the router.
module spi_ahb_loader
  import loader_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] HPROT_VAL   = 4'b0011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             spi_change,
  output logic             busy,
  output logic             error,
  spi_ahb_loader_if.master ahb
);

  parser_state_t p_state;
  ahb_state_t    a_state;
  logic        cs_idle, byte_valid;
  logic [7:0]  rx_byte, status;
  logic [1:0]  byte_cnt;
  logic [23:0] word_sr;
  logic [31:0] addr, buf_addr, buf_data;
  logic        buf_full, spi_change_sent, pop, xfer_err;

  assign status = {5'b0, error, spi_change_sent, busy};

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .status    (status),
    .cs_idle   (cs_idle),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .miso      (miso)
  );

  assign ahb.hsize     = HSIZE_WORD;
  assign ahb.hburst    = HBURST_SINGLE;
  assign ahb.hprot     = HPROT_VAL;
  assign ahb.hmastlock = 1'b0;

  // The AHB side takes the buffered word whenever it is idle or finishing a data phase.
  assign pop      = buf_full && (a_state == A_IDLE || (a_state == A_DATA && ahb.hready));
  assign xfer_err = (a_state == A_DATA) && ahb.hready && ahb.hresp;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state         <= P_IDLE;
      byte_cnt        <= '0;
      word_sr         <= '0;
      addr            <= '0;
      buf_full        <= 1'b0;
      buf_addr        <= '0;
      buf_data        <= '0;
      spi_change      <= 1'b0;
      spi_change_sent <= 1'b0;
      error           <= 1'b0;
    end else begin
      spi_change <= 1'b0;
      if (pop)      buf_full <= 1'b0;
      if (xfer_err) error    <= 1'b1;
      if (cs_idle) begin
        p_state  <= P_IDLE;
        byte_cnt <= '0;
      end else begin
        case (p_state)
          P_IDLE: p_state <= P_CMD;
          P_CMD: if (byte_valid) begin
            case (rx_byte)
              CMD_WRITE: p_state <= P_ADDR;
              CMD_RUN:   p_state <= P_RUN;
              default:   p_state <= P_DISCARD;
            endcase
          end
          P_ADDR: if (byte_valid) begin
            word_sr  <= {word_sr[15:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr    <= {word_sr, rx_byte[7:2], 2'b00};
              p_state <= P_DATA;
            end
          end
          P_DATA: if (byte_valid) begin
            word_sr  <= {word_sr[15:0], rx_byte};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (buf_full) begin
                error <= 1'b1;
              end else begin
                buf_full <= 1'b1;
                buf_addr <= addr;
                buf_data <= {word_sr, rx_byte};
              end
              addr <= addr + 32'd4;
            end
          end
          P_RUN: if (a_state == A_IDLE && !buf_full) begin
            spi_change      <= 1'b1;
            spi_change_sent <= 1'b1;
            p_state         <= P_DISCARD;
          end
          P_DISCARD: ;
          default: p_state <= P_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_state    <= A_IDLE;
      ahb.htrans <= HTRANS_IDLE;
      ahb.hwrite <= 1'b0;
      ahb.haddr  <= '0;
      ahb.hwdata <= '0;
      busy       <= 1'b0;
    end else if (pop) begin
      a_state    <= A_ADDR;
      ahb.htrans <= HTRANS_NONSEQ;
      ahb.hwrite <= 1'b1;
      ahb.haddr  <= buf_addr;
      ahb.hwdata <= buf_data;
      busy       <= 1'b1;
    end else begin
      case (a_state)
        A_ADDR: if (ahb.hready) begin
          a_state    <= A_DATA;
          ahb.htrans <= HTRANS_IDLE;
          ahb.hwrite <= 1'b0;
        end
        A_DATA: if (ahb.hready) begin
          a_state <= A_IDLE;
          busy    <= 1'b0;
        end
        default: a_state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ahb_loader.sv
// Directed bench for spi_ahb_loader: table of single-word write frames plus
// hand-written sequences for address wrap, wait states, abort, run and reset.
module tb_spi_ahb_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  logic reset, sclk, cs_n, mosi, miso, spi_change, busy, error;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   sc_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;
  xfer_t wq[$];
  logic        dp;
  logic [31:0] dp_addr;

  typedef struct {
    logic [31:0] addr_in;
    logic [31:0] data;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;
  vec_t vecs[5];

  spi_ahb_loader_if ahb ();

  spi_ahb_loader #(.SYNC_STAGES(2), .HPROT_VAL(4'b0011)) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .spi_change(spi_change),
    .busy      (busy),
    .error     (error),
    .ahb       (ahb.master)
  );

  always #5 clk = ~clk;

  // Bus monitor: records each completed write as {address-phase addr, data-phase hwdata}.
  always @(negedge clk) begin
    if (reset) begin
      dp <= 1'b0;
    end else begin
      if (spi_change) sc_cnt <= sc_cnt + 1;
      if (dp && ahb.hready) begin
        wq.push_back('{addr: dp_addr, data: ahb.hwdata});
        dp <= 1'b0;
      end
      if (ahb.htrans == HTRANS_NONSEQ && ahb.hwrite && ahb.hready) begin
        dp      <= 1'b1;
        dp_addr <= ahb.haddr;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #40;
      rx[i] = miso;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    @(posedge clk);
    #1;
    cs_n = 1'b0;
    #80;
  endtask

  task automatic frame_end();
    #80;
    cs_n = 1'b1;
    #200;
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [31:0] w0,
                             input logic [31:0] w1, input int nbytes);
    logic [7:0]  rx;
    logic [63:0] d;
    d = {w0, w1};
    frame_begin();
    spi_xfer(CMD_WRITE, rx);
    for (int i = 0; i < 4; i++) spi_xfer(a[31-8*i -: 8], rx);
    for (int i = 0; i < nbytes; i++) spi_xfer(d[63-8*i -: 8], rx);
    frame_end();
  endtask

  task automatic one_byte_frame(input logic [7:0] tx, output logic [7:0] rx);
    frame_begin();
    spi_xfer(tx, rx);
    frame_end();
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 300 && wq.size() < n; i++) @(posedge clk);
    check("xfer_count", wq.size(), n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_htrans"},     {30'b0, ahb.htrans}, 32'h0);
    check({tag, "_hwrite"},     {31'b0, ahb.hwrite}, 32'h0);
    check({tag, "_haddr"},      ahb.haddr,           32'h0);
    check({tag, "_hwdata"},     ahb.hwdata,          32'h0);
    check({tag, "_miso"},       {31'b0, miso},       32'h0);
    check({tag, "_spi_change"}, {31'b0, spi_change}, 32'h0);
    check({tag, "_busy"},       {31'b0, busy},       32'h0);
    check({tag, "_error"},      {31'b0, error},      32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st;
    bit         seen;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_4003, 32'h0123_4567, 32'h0000_4000, 32'h0123_4567};
    vecs[2] = '{32'h8000_1236, 32'hA5A5_5A5A, 32'h8000_1234, 32'hA5A5_5A5A};
    vecs[3] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0001};
    vecs[4] = '{32'h0000_C00D, 32'hFFFF_FFFF, 32'h0000_C00C, 32'hFFFF_FFFF};

    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    ahb.hready = 1'b1; ahb.hresp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("init");
    check("init_hsize", {29'b0, ahb.hsize}, 32'h2);
    check("init_hprot", {28'b0, ahb.hprot}, 32'h3);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      wq.delete();
      write_frame(vecs[v].addr_in, vecs[v].data, 32'h0, 4);
      wait_xfers(1);
      if (wq.size() > 0) begin
        check($sformatf("vec%0d_haddr", v),  wq[0].addr, vecs[v].exp_addr);
        check($sformatf("vec%0d_hwdata", v), wq[0].data, vecs[v].exp_data);
      end
    end

    // Two words starting at the top of the address space wrap to zero.
    wq.delete();
    write_frame(32'hFFFF_FFFC, 32'h1357_9BDF, 32'h2468_ACE0, 8);
    wait_xfers(2);
    if (wq.size() > 1) begin
      check("wrap_addr0", wq[0].addr, 32'hFFFF_FFFC);
      check("wrap_data0", wq[0].data, 32'h1357_9BDF);
      check("wrap_addr1", wq[1].addr, 32'h0000_0000);
      check("wrap_data1", wq[1].data, 32'h2468_ACE0);
    end

    // Five wait states in the first data phase.
    wq.delete();
    fork
      write_frame(32'h0000_0020, 32'h1111_1111, 32'h2222_2222, 8);
      begin
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
          @(negedge clk);
          seen = (ahb.htrans == HTRANS_NONSEQ);
        end
        check("stall_nonseq_seen", {31'b0, seen}, 32'h1);
        if (seen) begin
          @(posedge clk);
          #1 ahb.hready = 1'b0;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_htrans", {30'b0, ahb.htrans}, 32'h0);
            check("stall_busy",   {31'b0, busy},       32'h1);
            check("stall_haddr",  ahb.haddr,           32'h0000_0020);
            check("stall_hwdata", ahb.hwdata,          32'h1111_1111);
            @(posedge clk);
          end
          #1 ahb.hready = 1'b1;
        end
      end
    join
    wait_xfers(2);
    if (wq.size() > 1) begin
      check("stall_addr0", wq[0].addr, 32'h0000_0020);
      check("stall_data0", wq[0].data, 32'h1111_1111);
      check("stall_addr1", wq[1].addr, 32'h0000_0024);
      check("stall_data1", wq[1].data, 32'h2222_2222);
    end

    // Frame aborted after two data bytes, then a clean frame.
    wq.delete();
    write_frame(32'h0000_0030, 32'hAABB_0000, 32'h0, 2);
    repeat (50) @(posedge clk);
    check("abort_no_xfer", wq.size(), 0);
    write_frame(32'h0000_0040, 32'hCAFE_F00D, 32'h0, 4);
    wait_xfers(1);
    if (wq.size() > 0) begin
      check("after_abort_addr", wq[0].addr, 32'h0000_0040);
      check("after_abort_data", wq[0].data, 32'hCAFE_F00D);
    end

    // Run command: single-cycle pulse, then status reports spi_change_sent.
    sc_cnt = 0;
    one_byte_frame(CMD_RUN, st);
    check("run_pulse_cycles", sc_cnt, 1);
    one_byte_frame(8'h00, st);
    check("status_after_run", {24'b0, st}, 32'h02);

    // Error response on a write sets the sticky error flag.
    ahb.hresp = 1'b1;
    write_frame(32'h0000_0050, 32'h1234_5678, 32'h0, 4);
    repeat (20) @(posedge clk);
    ahb.hresp = 1'b0;
    check("error_flag", {31'b0, error}, 32'h1);
    one_byte_frame(8'h00, st);
    check("status_after_err", {24'b0, st}, 32'h06);

    // Reset while an address phase is stuck waiting on hready.
    @(posedge clk);
    #1 ahb.hready = 1'b0;
    write_frame(32'h0000_0060, 32'h0102_0304, 32'h0, 4);
    check("pre_reset_htrans", {30'b0, ahb.htrans}, {30'b0, HTRANS_NONSEQ});
    check("pre_reset_busy",   {31'b0, busy},       32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    ahb.hready = 1'b1;
    wq.delete();
    repeat (20) @(posedge clk);
    check("post_reset_no_xfer", wq.size(), 0);
    one_byte_frame(8'h00, st);
    check("status_after_reset", {24'b0, st}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
